// File: rtl/minicpu_pkg.sv
// Shared types for the minicpu memory path.
// Owner encoding, response tag layout and latency bound.
package minicpu_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_write;
  } tag_t;

  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/resp_tag_pipe.sv
// Fixed-latency tag pipeline for in-flight SRAM accesses.
// Exposes only the oldest stage, which lines up with sram_rdata.
module resp_tag_pipe
  import minicpu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [RD_LAT-1:0] stg;

  // shift one stage per cycle; reset drops every in-flight tag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stg <= '0;
    end else begin
      stg[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign tag_out = stg[RD_LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM between fetch and data ports.
// Responses are routed back by a tag pipeline matching read latency.
module sram_arbiter
  import minicpu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  owner_e last_grant;
  logic   gnt_i;
  logic   gnt_d;
  tag_t   tag_in;
  tag_t   tag_out;
  logic   rsp_unused;

  // pick a winner; on a tie the side not granted last time wins
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (resetn) begin
      case ({inst_req, data_req})
        2'b11: begin
          gnt_i = (last_grant == OWN_DATA);
          gnt_d = (last_grant == OWN_INST);
        end
        2'b10:   gnt_i = 1'b1;
        2'b01:   gnt_d = 1'b1;
        default: ;
      endcase
    end
  end

  // remember who won the most recent accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= OWN_DATA;
    end else if (gnt_i) begin
      last_grant <= OWN_INST;
    end else if (gnt_d) begin
      last_grant <= OWN_DATA;
    end
  end

  assign inst_addr_ok = gnt_i;
  assign data_addr_ok = gnt_d;

  assign sram_en    = gnt_i | gnt_d;
  assign sram_addr  = gnt_d ? data_addr : inst_addr;
  assign sram_wdata = data_wdata;
  assign sram_we    = (gnt_d && data_wr) ? data_wstrb : 4'b0000;

  assign tag_in.valid    = sram_en;
  assign tag_in.owner    = gnt_d ? OWN_DATA : OWN_INST;
  assign tag_in.is_write = gnt_d & data_wr;

  resp_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tags (
    .clk     (clk),
    .resetn  (resetn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // stores complete through the same slot as loads
  assign rsp_unused = tag_out.is_write;

  assign inst_data_ok = tag_out.valid && (tag_out.owner == OWN_INST);
  assign data_data_ok = tag_out.valid && (tag_out.owner == OWN_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model plus queue-based reference.
// Directed steps followed by a randomized phase.
module tb_sram_arbiter;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(.RD_LAT(L)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  // synchronous SRAM with L-cycle read latency
  logic [31:0] mem  [256];
  logic [31:0] rd_q [L];
  assign sram_rdata = rd_q[L-1];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < L; i++) rd_q[i] = 32'h0;
    mem[0] = 32'h02804002;
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    mem[3] = 32'h33333333;
  end

  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) rd_q[i] <= rd_q[i-1];
    if (sram_en) begin
      rd_q[0] <= mem[sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr[9:2]][8*b+:8] <= sram_wdata[8*b+:8];
    end
  end

  // reference model state
  typedef struct {
    int          due;
    bit          own;
    bit          wr;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] rmem [256];
  rsp_t        q[$];
  bit          m_last;
  int          cyc;
  bit          acc_i;
  bit          acc_d;
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)",
                tag, obs, exp, cyc);
  endtask

  task automatic step();
    bit          ei;
    bit          ed;
    bit          ri;
    bit          rd;
    logic [3:0]  ewe;
    logic [7:0]  idx;
    rsp_t        r;
    @(negedge clk);
    ei = 1'b0;
    ed = 1'b0;
    if (resetn) begin
      if (inst_req && data_req) begin
        ei = m_last;
        ed = !m_last;
      end else begin
        ei = inst_req;
        ed = data_req;
      end
    end
    ri = 1'b0;
    rd = 1'b0;
    if (resetn && q.size() > 0 && q[0].due == cyc) begin
      ri = !q[0].own;
      rd = q[0].own;
    end
    ewe = (ed && data_wr) ? data_wstrb : 4'h0;
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(ei));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(ed));
    chk("sram_en", 32'(sram_en), 32'(ei | ed));
    chk("sram_we", 32'(sram_we), 32'(ewe));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(ri));
    chk("data_data_ok", 32'(data_data_ok), 32'(rd));
    if (ei || ed)
      chk("sram_addr", sram_addr, ed ? data_addr : inst_addr);
    if (ed && data_wr)
      chk("sram_wdata", sram_wdata, data_wdata);
    if (ri)
      chk("inst_rdata", inst_rdata, q[0].data);
    if (rd && !q[0].wr)
      chk("data_rdata", data_rdata, q[0].data);
    if (!resetn) begin
      q.delete();
      m_last = 1'b1;
    end else begin
      if (ri || rd) void'(q.pop_front());
      if (ei || ed) begin
        idx   = ed ? data_addr[9:2] : inst_addr[9:2];
        r.due = cyc + L;
        r.own = ed;
        r.wr  = ed && data_wr;
        if (r.wr) begin
          for (int b = 0; b < 4; b++)
            if (data_wstrb[b]) rmem[idx][8*b+:8] = data_wdata[8*b+:8];
          r.data = 32'h0;
        end else begin
          r.data = rmem[idx];
        end
        q.push_back(r);
        m_last = ed;
      end
    end
    acc_i = ei;
    acc_d = ed;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    m_last  = 1'b1;
    acc_i   = 1'b0;
    acc_d   = 1'b0;
    for (int i = 0; i < 256; i++) rmem[i] = 32'h0;
    rmem[0] = 32'h02804002;
    rmem[1] = 32'h11111111;
    rmem[2] = 32'h22222222;
    rmem[3] = 32'h33333333;
    resetn     = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;

    // reset, then quiet after release
    repeat (3) step();
    resetn = 1'b1;
    repeat (10) step();

    // single fetch
    inst_req  = 1'b1;
    inst_addr = 32'h1c000000;
    step();
    idle(L + 1);

    // tie-break alternation
    inst_req  = 1'b1;
    inst_addr = 32'h1c000010;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h1c000100;
    repeat (6) begin
      step();
      if (acc_i) inst_addr = inst_addr + 32'h4;
    end
    idle(L + 1);

    // store then load same word
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h1c000200;
    data_wdata = 32'hdeadbeef;
    data_wstrb = 4'b0011;
    step();
    data_wr = 1'b0;
    step();
    idle(L + 1);

    // back-to-back fetches
    inst_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'(i * 4);
      step();
    end
    idle(L + 2);

    // reset with a fetch in flight
    inst_req  = 1'b1;
    inst_addr = 32'h1c000004;
    step();
    inst_req = 1'b0;
    resetn   = 1'b0;
    step();
    resetn = 1'b1;
    idle(L + 3);

    // randomized traffic
    repeat (500) begin
      if (!inst_req || acc_i) begin
        inst_req  = 1'($urandom_range(0, 1));
        inst_addr = {20'h1c000, 2'b00, 8'($urandom), 2'($urandom)};
      end
      if (!data_req || acc_d) begin
        data_req   = 1'($urandom_range(0, 1));
        data_wr    = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom);
        data_addr  = {20'h1c000, 2'b00, 8'($urandom), 2'($urandom)};
        data_wdata = $urandom;
      end
      resetn = ($urandom_range(0, 99) != 0);
      step();
    end
    resetn = 1'b1;
    idle(L + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM between the CPU's instruction-fetch port and data port, so the pipelined minicpu can run from a unified memory. Both requesters use a req/addr_ok/data_ok split-transaction handshake. The arbiter grants at most one access per cycle with round-robin tie-breaking. It tracks in-flight accesses through a fixed-latency tag pipeline and routes each response back to its owner.

## Interface
- RD_LAT, 1: SRAM read latency in cycles, legal range 1..4; `sram_rdata` is valid RD_LAT cycles after the access cycle.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch request; must hold, with `inst_addr`, until `inst_addr_ok`.
- inst_addr  in  32  fetch byte address.
- inst_addr_ok  out  1  fetch accepted this cycle.
- inst_data_ok  out  1  fetch data returned this cycle.
- inst_rdata  out  32  fetch data, valid with `inst_data_ok`.
- data_req  in  1  data request; must hold, with `data_wr`/`data_wstrb`/`data_addr`/`data_wdata`, until `data_addr_ok`.
- data_wr  in  1  1 = store, 0 = load.
- data_wstrb  in  4  byte enables for stores.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data access accepted this cycle.
- data_data_ok  out  1  load data returned, or store completed, this cycle.
- data_rdata  out  32  load data, valid with `data_data_ok`.
- sram_en  out  1  SRAM access this cycle.
- sram_we  out  4  byte write enables; 0 for reads.
- sram_addr  out  32  SRAM byte address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.

## Operation
- **Grant (combinational from current-cycle req and `last_grant`):**
  - Only one requester asserts req: it is granted.
  - Both assert req: the one not in `last_grant` is granted.
  - Neither asserts req: no grant, `sram_en` = 0.
- **Accept:** a granted access is accepted in that same cycle. `*_addr_ok` = 1 and `sram_en` = 1.
  - `sram_addr`/`sram_we`/`sram_wdata` are muxed from the winner.
  - `sram_we` = `data_wstrb` for a data store, otherwise 0.
- **last_grant:** a register that updates to the winner on every accept. Reset value selects DATA, so INST wins the first tie.
- **Tag pipeline:** RD_LAT stages of {valid, owner, is_write}. On accept, stage 0 loads {1, winner, wr}. Stages shift every cycle.
- **Response:** when the last stage is valid:
  - Owner INST: `inst_data_ok` = 1.
  - Owner DATA: `data_data_ok` = 1, for both loads and stores.
- **Response data:** `inst_rdata` and `data_rdata` both equal `sram_rdata`. They are don't-care when the matching `*_data_ok` is low.
- **Ordering:** responses return in acceptance order. Back-to-back accepts every cycle are legal, with no bubbles.
- **Outstanding limit:** none beyond the pipeline depth. Requesters must always sink `data_ok`; there is no response backpressure.
- **Address:** passed through unmodified; the low 2 bits are ignored by the SRAM.

## Timing
- **Reset values:**
  - All tag stages invalid; `last_grant` = DATA.
  - `*_addr_ok` and `sram_en` follow req combinationally. Under reset they are forced to 0.
  - `*_data_ok` = 0, `sram_we` = 0.
- **Latency:** accept in cycle N gives `data_ok` in cycle N+RD_LAT.
- **Reset asserted mid-transaction:** in-flight tags are cleared immediately. No `data_ok` is issued for accesses accepted before reset.
- **Reset release:** the first accept is possible in the first cycle with `resetn` high.
- **Simultaneous response and accept in the same cycle:** both occur; no interaction.
- **Starvation bound:** with both requesters continuously requesting, grants strictly alternate. Worst-case wait is 1 cycle.
- **Requester dropping req before addr_ok:** protocol violation. It is not checked and the behaviour is undefined.

## Structure
- Shared package `minicpu_pkg` contents:
  - Owner enum `OWN_INST`/`OWN_DATA`.
  - Tag struct {valid, owner, is_write}.
  - Constant `RD_LAT_MAX` = 4.
- Sub-module `resp_tag_pipe`: parameterised by RD_LAT. It is a shift register of tags with async clear and exposes only the last stage.
- The top level holds the grant logic, the `last_grant` register, the SRAM mux and the response decode.

## Test plan
- **Reset:** reset, then release with no reqs → all outputs 0; `sram_en` = 0 for 10 cycles.
- **Single fetch, RD_LAT = 1:** `inst_req` with `inst_addr` = 0x1c000000; SRAM preloaded with 0x02804002 → `inst_addr_ok` in cycle N, `inst_data_ok` with `inst_rdata` = 0x02804002 in cycle N+1.
- **Tie-break, alternation:** `inst_req` and `data_req` held high for 6 cycles, load from 0x1c000100 → grant order I,D,I,D,I,D; responses in the same order, RD_LAT later.
- **Store then load:** store 0xdeadbeef to 0x1c000200 with `wstrb` = 4'b0011, then load the same address → `data_data_ok` for the store; load returns 0x0000beef over a zero-initialised word.
- **RD_LAT = 3, back-to-back:** 4 fetches at 0x0, 0x4, 0x8, 0xc → `addr_ok` on 4 consecutive cycles; `data_ok` on cycles N+3..N+6 with in-order data.
- **Reset mid-flight:** with RD_LAT = 2, accept a fetch, then assert `resetn` low 1 cycle later → no `inst_data_ok` ever appears for that fetch.
